// File: rtl/fmul_issue.sv
// Issue/retire controller for a fixed-latency, non-stallable fmul pipeline.
// Tracks in-flight ops with a valid/tag shift chain and buffers results in a
// tagged first-word-fall-through FIFO whose slots are reserved at issue time.
module fmul_issue #(
    parameter int LAT   = 3,
    parameter int TAG_W = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_x1_i,
    input  logic [31:0]      in_x2_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic [31:0]      mul_x1_o,
    output logic [31:0]      mul_x2_o,
    input  logic [31:0]      mul_y_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_y_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [LAT-1:0]            vld_q, vld_d;
    logic [LAT-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [31:0]               y_mem_q [DEPTH];
    logic [TAG_W-1:0]          t_mem_q [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [CW-1:0] inflight;

    // Both ports transfer on a rising edge where valid & ready are high; valid
    // never waits on ready, and in_ready depends on registers only.
    assign accept = in_valid_i & in_ready_o;
    assign push   = vld_q[LAT-1];
    assign pop    = out_valid_o & out_ready_i;

    assign mul_x1_o = in_x1_i;
    assign mul_x2_o = in_x2_i;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight = inflight + CW'(vld_q[k]);
        end
    end

    // Every in-flight op already owns a FIFO slot, so fmul never needs to stall.
    assign in_ready_o  = ({1'b0, inflight} + {1'b0, count_q}) < DEPTH_SUM;
    assign busy_o      = (inflight != '0) || (count_q != '0);
    assign out_valid_o = (count_q != '0);
    assign out_y_o     = out_valid_o ? y_mem_q[rd_ptr_q] : '0;
    assign out_tag_o   = out_valid_o ? t_mem_q[rd_ptr_q] : '0;

    always_comb begin
        vld_d    = vld_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        vld_d[0] = accept;
        tag_d[0] = in_tag_i;
        for (int k = 1; k < LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            tag_d[k] = tag_q[k-1];
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        // Dropping the valid bits is enough to discard results still inside fmul.
        if (flush_i) begin
            vld_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            vld_q    <= '0;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i && !flush_i && push) begin
            y_mem_q[wr_ptr_q] <= mul_y_i;
            t_mem_q[wr_ptr_q] <= tag_q[LAT-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i && !flush_i) begin
            assert (!(push && !pop && count_q == DEPTH_CNT));
        end
    end

endmodule
